// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Writeback stage plus 32x32 register file for a 5-stage pipeline.
//            Selects the writeback data and destination, commits it on the
//            next rising edge, and forwards it into same-cycle reads. It also
//            holds a sticky halt state and cycle/write performance counters.
// Ports    : clk, rst                    - clock, synchronous active-high reset
//            wb_rw, wb_regwrite,
//            wb_memtoreg, wb_jal, wb_lui - MEM/WB control
//            wb_imm, wb_pc, wb_alu,
//            wb_ram                      - MEM/WB data fields
//            wb_halt                     - halt marker carried by the instruction
//            ra, rb / rd_a, rd_b         - ID-stage read ports (combinational)
//            wb_we, wb_dest, wb_data     - effective write, for forwarding
//            halted                      - sticky halt flag
//            cycle_cnt, write_cnt        - performance counters
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wb_rw,
  input  logic        wb_regwrite,
  input  logic        wb_memtoreg,
  input  logic        wb_jal,
  input  logic        wb_lui,
  input  logic [31:0] wb_imm,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_alu,
  input  logic [31:0] wb_ram,
  input  logic        wb_halt,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b,
  output logic        wb_we,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        halted,
  output logic [31:0] cycle_cnt,
  output logic [31:0] write_cnt
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [4:0] LINK_REG = 5'd31;

  state_t      state_q, state_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] write_cnt_q, write_cnt_d;

  // Register 0 has no storage; regs_view gives a uniform 0..31 read space.
  logic [31:0] regs_q    [1:31];
  logic [31:0] regs_d    [1:31];
  logic [31:0] regs_view [0:31];

  // Writeback selection: jal outranks lui, which outranks memtoreg.
  always_comb begin
    wb_data = wb_alu;
    if (wb_jal) begin
      wb_data = wb_pc + 32'd1;
    end else if (wb_lui) begin
      wb_data = {wb_imm[15:0], 16'h0000};
    end else if (wb_memtoreg) begin
      wb_data = wb_ram;
    end
  end

  assign wb_dest = wb_jal ? LINK_REG : wb_rw;
  assign halted  = (state_q == ST_HALT);

  // A halting instruction never commits, and nothing commits once halted.
  assign wb_we = wb_regwrite & ~wb_halt & ~halted & (wb_dest != 5'd0);

  // State and counter next-state logic.
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    write_cnt_d = write_cnt_q;
    if (state_q == ST_RUN) begin
      // The edge that enters HALT is still counted as a run cycle.
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (wb_halt) begin
        state_d = ST_HALT;
      end
    end
    if (wb_we) begin
      write_cnt_d = write_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cycle_cnt_q <= '0;
      write_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      write_cnt_q <= write_cnt_d;
    end
  end

  assign regs_view[0] = '0;

  generate
    for (genvar i = 1; i < 32; i++) begin : g_regs
      always_comb begin
        regs_d[i] = regs_q[i];
        if (wb_we && (wb_dest == 5'(i))) begin
          regs_d[i] = wb_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          regs_q[i] <= '0;
        end else begin
          regs_q[i] <= regs_d[i];
        end
      end

      assign regs_view[i] = regs_q[i];
    end
  endgenerate

  // Write-through bypass: a write in flight is visible to reads this cycle.
  // wb_we already excludes register 0, so ra/rb == 0 always read zero.
  assign rd_a = (wb_we && (ra == wb_dest)) ? wb_data : regs_view[ra];
  assign rd_b = (wb_we && (rb == wb_dest)) ? wb_data : regs_view[rb];

  assign cycle_cnt = cycle_cnt_q;
  assign write_cnt = write_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Directed self-checking bench for wb_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_rw;
  logic        wb_regwrite;
  logic        wb_memtoreg;
  logic        wb_jal;
  logic        wb_lui;
  logic [31:0] wb_imm;
  logic [31:0] wb_pc;
  logic [31:0] wb_alu;
  logic [31:0] wb_ram;
  logic        wb_halt;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] write_cnt;

  int n_cmp;
  int n_bad;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .wb_rw      (wb_rw),
    .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg),
    .wb_jal     (wb_jal),
    .wb_lui     (wb_lui),
    .wb_imm     (wb_imm),
    .wb_pc      (wb_pc),
    .wb_alu     (wb_alu),
    .wb_ram     (wb_ram),
    .wb_halt    (wb_halt),
    .ra         (ra),
    .rb         (rb),
    .rd_a       (rd_a),
    .rd_b       (rd_b),
    .wb_we      (wb_we),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .halted     (halted),
    .cycle_cnt  (cycle_cnt),
    .write_cnt  (write_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_rw = 5'd0; wb_regwrite = 1'b0; wb_memtoreg = 1'b0; wb_jal = 1'b0;
    wb_lui = 1'b0; wb_imm = '0; wb_pc = '0; wb_alu = '0; wb_ram = '0;
    wb_halt = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    ra = 5'd0; rb = 5'd0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    ra = 5'd5;
    #1;
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_write_cnt", write_cnt, 32'd0);
    chk("rst_halted",    {31'd0, halted}, 32'd0);
    chk("rst_reg5",      rd_a, 32'd0);

    // ALU write to r5
    wb_regwrite = 1'b1; wb_rw = 5'd5; wb_alu = 32'h1234;
    #1;
    chk("alu_we",   {31'd0, wb_we}, 32'd1);
    chk("alu_dest", {27'd0, wb_dest}, 32'd5);
    chk("alu_data", wb_data, 32'h1234);
    tick();                                   // cycle_cnt = 1
    idle();
    #1;
    chk("alu_reg5",  rd_a, 32'h1234);
    chk("alu_wcnt",  write_cnt, 32'd1);
    chk("alu_ccnt",  cycle_cnt, 32'd1);

    // Memory write to r7 with same-cycle bypass on rb
    wb_regwrite = 1'b1; wb_rw = 5'd7; wb_ram = 32'hDEAD_BEEF; wb_memtoreg = 1'b1;
    wb_alu = 32'h0000_0BAD; rb = 5'd7;
    #1;
    chk("byp_rd_b", rd_b, 32'hDEAD_BEEF);
    tick();                                   // cycle 2
    idle();
    #1;
    chk("mem_reg7", rd_b, 32'hDEAD_BEEF);
    chk("mem_wcnt", write_cnt, 32'd2);

    // JAL with pc=0x10 links 0x11 into r31, not into rw=3
    wb_regwrite = 1'b1; wb_jal = 1'b1; wb_pc = 32'h10; wb_rw = 5'd3;
    #1;
    chk("jal_dest", {27'd0, wb_dest}, 32'd31);
    chk("jal_data", wb_data, 32'h11);
    tick();                                   // cycle 3
    idle();
    ra = 5'd31; rb = 5'd3;
    #1;
    chk("jal_r31", rd_a, 32'h11);
    chk("jal_r3",  rd_b, 32'd0);

    // JAL with pc wrap: r31 becomes 0
    wb_regwrite = 1'b1; wb_jal = 1'b1; wb_pc = 32'hFFFF_FFFF; wb_rw = 5'd3;
    tick();                                   // cycle 4
    idle();
    #1;
    chk("jalwrap_r31", rd_a, 32'd0);
    chk("jalwrap_r3",  rd_b, 32'd0);
    chk("jalwrap_wcnt", write_cnt, 32'd4);

    // LUI beats memtoreg
    wb_regwrite = 1'b1; wb_lui = 1'b1; wb_imm = 32'h0000_ABCD; wb_rw = 5'd4;
    wb_memtoreg = 1'b1; wb_ram = 32'h5555_5555;
    tick();                                   // cycle 5
    idle();
    ra = 5'd4;
    #1;
    chk("lui_reg4", rd_a, 32'hABCD_0000);
    chk("lui_wcnt", write_cnt, 32'd5);

    // Writes to r0 are discarded
    wb_regwrite = 1'b1; wb_rw = 5'd0; wb_alu = 32'd5; ra = 5'd0;
    #1;
    chk("r0_we",   {31'd0, wb_we}, 32'd0);
    chk("r0_byp",  rd_a, 32'd0);
    tick();                                   // cycle 6
    idle();
    #1;
    chk("r0_read", rd_a, 32'd0);
    chk("r0_wcnt", write_cnt, 32'd5);

    // jal outranks lui (combinational only, no edge)
    wb_jal = 1'b1; wb_lui = 1'b1; wb_pc = 32'h20; wb_imm = 32'h1; wb_rw = 5'd4;
    #1;
    chk("prio_data", wb_data, 32'h21);
    chk("prio_dest", {27'd0, wb_dest}, 32'd31);
    idle();

    tick(); tick(); tick(); tick();           // cycle 10
    #1;
    chk("pre_halt_ccnt", cycle_cnt, 32'd10);

    // Halt together with a write to r9: halt wins
    wb_halt = 1'b1; wb_regwrite = 1'b1; wb_rw = 5'd9; wb_alu = 32'h99; ra = 5'd9;
    #1;
    chk("halt_we",  {31'd0, wb_we}, 32'd0);
    tick();
    idle();
    #1;
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_ccnt", cycle_cnt, 32'd11);
    chk("halt_wcnt", write_cnt, 32'd5);
    chk("halt_reg9", rd_a, 32'd0);

    // Writes ignored while halted, reads still work
    wb_regwrite = 1'b1; wb_rw = 5'd9; wb_alu = 32'h77; rb = 5'd5;
    #1;
    chk("hw_we", {31'd0, wb_we}, 32'd0);
    tick();
    #1;
    chk("hw_reg9", rd_a, 32'd0);
    chk("hw_reg5", rd_b, 32'h1234);
    chk("hw_ccnt", cycle_cnt, 32'd11);
    chk("hw_wcnt", write_cnt, 32'd5);

    // Reset in HALT, with a write pending
    rst = 1'b1; wb_rw = 5'd10; wb_alu = 32'hAAAA;
    tick();
    rst = 1'b0;
    idle();
    ra = 5'd5; rb = 5'd31;
    #1;
    chk("rr_halted", {31'd0, halted}, 32'd0);
    chk("rr_ccnt",   cycle_cnt, 32'd0);
    chk("rr_wcnt",   write_cnt, 32'd0);
    chk("rr_reg5",   rd_a, 32'd0);
    ra = 5'd10;
    #1;
    chk("rr_reg10",  rd_a, 32'd0);

    // Writes resume after reset
    wb_regwrite = 1'b1; wb_rw = 5'd9; wb_alu = 32'h55; ra = 5'd9;
    tick();
    idle();
    #1;
    chk("resume_reg9", rd_a, 32'h55);
    chk("resume_wcnt", write_cnt, 32'd1);
    chk("resume_ccnt", cycle_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
